// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
//   Shared definitions for the register-file writeback arbiter:
//   bus widths, register-file geometry, the arbiter state encoding
//   and small index helpers.
// -----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

    // Bus widths used on the writeback / decode ports.
    localparam int V8  = 8;
    localparam int V32 = 32;

    // Register-file geometry: 32 architectural registers, 5-bit index.
    localparam int REG_COUNT = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [REG_COUNT-1:0] reg_mask_t;

    // Which requester won the most recent grant.
    typedef enum logic {
        LAST_ALU = 1'b0,
        LAST_MEM = 1'b1
    } arb_state_t;

    // One-hot mask for a register index.
    function automatic reg_mask_t idx_mask(input reg_idx_t idx);
        reg_mask_t m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage : regfile_wb_arbiter_pkg

// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
//   Bundles every non-clock signal of the writeback arbiter.
//     ALU writeback : alu_valid, alu_rd, alu_data -> alu_ready
//     MEM writeback : mem_valid, mem_rd, mem_data -> mem_ready
//     Decode        : issue_valid, issue_rd, q_r1, q_r2 -> stall
//     Bank write    : wr_enable, wr_rw, wr_data
//     Status        : pending, wb_count
//   master = the pipeline side driving requests; slave = the arbiter.
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic           alu_valid;
    logic [V8-1:0]  alu_rd;
    logic [V32-1:0] alu_data;
    logic           alu_ready;

    logic           mem_valid;
    logic [V8-1:0]  mem_rd;
    logic [V32-1:0] mem_data;
    logic           mem_ready;

    logic           issue_valid;
    logic [V8-1:0]  issue_rd;
    logic [V8-1:0]  q_r1;
    logic [V8-1:0]  q_r2;
    logic           stall;

    logic           wr_enable;
    logic [V8-1:0]  wr_rw;
    logic [V32-1:0] wr_data;

    logic [V32-1:0] pending;
    logic [V32-1:0] wb_count;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output issue_valid, issue_rd, q_r1, q_r2,
        input  alu_ready, mem_ready, stall,
        input  wr_enable, wr_rw, wr_data, pending, wb_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  issue_valid, issue_rd, q_r1, q_r2,
        output alu_ready, mem_ready, stall,
        output wr_enable, wr_rw, wr_data, pending, wb_count
    );

endinterface : regfile_wb_arbiter_if

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//   Outstanding-write mask for the register file plus a two-port stall lookup.
//     clock, reset_n     : clock, async active-low reset
//     set_en, set_idx    : an issuing instruction will write set_idx
//     clr_en, clr_idx    : a writeback for clr_idx commits this edge
//     q_idx1, q_idx2     : source registers queried by decode
//     pending            : bit i set while register i has a write in flight
//     stall              : either queried source is pending
//   Register 0 is hard-wired and never pending. When set and clear hit the
//   same index on one edge, the set wins: it belongs to a younger producer.
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_wb_arbiter_pkg::*;
(
    input  logic      clock,
    input  logic      reset_n,
    input  logic      set_en,
    input  reg_idx_t  set_idx,
    input  logic      clr_en,
    input  reg_idx_t  clr_idx,
    input  reg_idx_t  q_idx1,
    input  reg_idx_t  q_idx2,
    output reg_mask_t pending,
    output logic      stall
);

    reg_mask_t pending_q;
    reg_mask_t pending_d;
    reg_mask_t set_mask;
    reg_mask_t clr_mask;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        set_mask  = '0;
        clr_mask  = '0;
        pending_d = pending_q;

        if (set_en) set_mask = idx_mask(set_idx);
        if (clr_en) clr_mask = idx_mask(clr_idx);

        // Clear first, then set, so a same-index collision leaves the bit set.
        pending_d    = (pending_q & ~clr_mask) | set_mask;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!reset_n) pending_q <= '0;
        else          pending_q <= pending_d;
    end

    assign pending = pending_q;
    assign stall   = pending_q[q_idx1] | pending_q[q_idx2];

endmodule : regfile_scoreboard

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Arbitrates ALU and MEM writeback requests onto the single register-bank
//   write port and tracks outstanding writes for decode stall detection.
//     clock    : single clock, posedge
//     reset_n  : async active-low reset
//     bus      : regfile_wb_arbiter_if.slave (requests, decode, write port,
//                status)
//   RR_ENABLE = 1 alternates between requesters on conflict; 0 always
//   prefers MEM. Ready is combinational (same-cycle grant); the bank write
//   is registered and appears the cycle after the grant. Destination
//   register 0 is consumed but never written.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    regfile_wb_arbiter_if.slave  bus
);

    // -------------------------------------------------------------------------
    // Index extraction; bits [7:5] of every register index are don't-care.
    // -------------------------------------------------------------------------
    reg_idx_t alu_idx;
    reg_idx_t mem_idx;
    reg_idx_t issue_idx;
    reg_idx_t q1_idx;
    reg_idx_t q2_idx;

    assign alu_idx   = bus.alu_rd[REG_IDX_W-1:0];
    assign mem_idx   = bus.mem_rd[REG_IDX_W-1:0];
    assign issue_idx = bus.issue_rd[REG_IDX_W-1:0];
    assign q1_idx    = bus.q_r1[REG_IDX_W-1:0];
    assign q2_idx    = bus.q_r2[REG_IDX_W-1:0];

    logic unused_idx_bits;
    assign unused_idx_bits = ^{bus.alu_rd[V8-1:REG_IDX_W], bus.mem_rd[V8-1:REG_IDX_W],
                               bus.issue_rd[V8-1:REG_IDX_W], bus.q_r1[V8-1:REG_IDX_W],
                               bus.q_r2[V8-1:REG_IDX_W]};

    // -------------------------------------------------------------------------
    // Arbiter: state register + next-state / grant logic.
    // -------------------------------------------------------------------------
    arb_state_t state_q;
    arb_state_t state_d;
    logic       grant_alu;
    logic       grant_mem;

    always_ff @(posedge clock or negedge reset_n) begin
        // LAST_ALU after reset hands the first conflict to MEM.
        if (!reset_n) state_q <= LAST_ALU;
        else          state_q <= state_d;
    end

    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        state_d   = state_q;

        if (bus.alu_valid && bus.mem_valid) begin
            if (RR_ENABLE && (state_q == LAST_MEM)) grant_alu = 1'b1;
            else                                    grant_mem = 1'b1;
        end else if (bus.alu_valid) begin
            grant_alu = 1'b1;
        end else if (bus.mem_valid) begin
            grant_mem = 1'b1;
        end

        if (grant_alu)      state_d = LAST_ALU;
        else if (grant_mem) state_d = LAST_MEM;
    end

    // Ready is held low while reset is asserted, even if a request is present.
    assign bus.alu_ready = grant_alu & reset_n;
    assign bus.mem_ready = grant_mem & reset_n;

    // -------------------------------------------------------------------------
    // Granted request selection.
    // -------------------------------------------------------------------------
    logic           grant_any;
    reg_idx_t       sel_idx;
    logic [V32-1:0] sel_data;
    logic           commit;

    assign grant_any = grant_alu | grant_mem;
    assign sel_idx   = grant_mem ? mem_idx      : alu_idx;
    assign sel_data  = grant_mem ? bus.mem_data : bus.alu_data;
    assign commit    = grant_any && (sel_idx != '0);

    // -------------------------------------------------------------------------
    // Registered write port and commit counter.
    // -------------------------------------------------------------------------
    logic           wr_enable_q;
    reg_idx_t       wr_idx_q;
    logic [V32-1:0] wr_data_q;
    logic [V32-1:0] wb_count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_enable_q <= 1'b0;
            wr_idx_q    <= '0;
            wr_data_q   <= '0;
            wb_count_q  <= '0;
        end else begin
            wr_enable_q <= commit;
            if (commit) begin
                wr_idx_q   <= sel_idx;
                wr_data_q  <= sel_data;
                // Counted on the same edge that raises wr_enable, so the count
                // already includes the write visible on the port. Wraps freely.
                wb_count_q <= wb_count_q + 32'd1;
            end
        end
    end

    assign bus.wr_enable = wr_enable_q;
    assign bus.wr_rw     = {{(V8-REG_IDX_W){1'b0}}, wr_idx_q};
    assign bus.wr_data   = wr_data_q;
    assign bus.wb_count  = wb_count_q;

    // -------------------------------------------------------------------------
    // Scoreboard: issue sets, grant clears (bank forwarding covers the
    // commit cycle, so clearing at the grant edge is safe).
    // -------------------------------------------------------------------------
    reg_mask_t sb_pending;
    logic      sb_stall;

    regfile_scoreboard u_scoreboard (
        .clock   (clock),
        .reset_n (reset_n),
        .set_en  (bus.issue_valid),
        .set_idx (issue_idx),
        .clr_en  (grant_any),
        .clr_idx (sel_idx),
        .q_idx1  (q1_idx),
        .q_idx2  (q2_idx),
        .pending (sb_pending),
        .stall   (sb_stall)
    );

    assign bus.pending = sb_pending;
    assign bus.stall   = sb_stall;

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//   Directed bench for regfile_wb_arbiter. Two instances share identical
//   stimulus: dut_rr (round-robin) and dut_fp (fixed MEM priority). Inputs
//   change on the falling edge; outputs are sampled on the falling edge or
//   1 ns after an input change for the combinational paths.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    regfile_wb_arbiter_if bus_rr ();
    regfile_wb_arbiter_if bus_fp ();

    regfile_wb_arbiter #(.RR_ENABLE(1'b1)) dut_rr (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_rr)
    );

    regfile_wb_arbiter #(.RR_ENABLE(1'b0)) dut_fp (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_fp)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---- stimulus helpers (both DUTs see the same inputs) -------------------
    task automatic set_alu(input logic v, input logic [7:0] rd, input logic [31:0] d);
        bus_rr.alu_valid = v; bus_rr.alu_rd = rd; bus_rr.alu_data = d;
        bus_fp.alu_valid = v; bus_fp.alu_rd = rd; bus_fp.alu_data = d;
    endtask

    task automatic set_mem(input logic v, input logic [7:0] rd, input logic [31:0] d);
        bus_rr.mem_valid = v; bus_rr.mem_rd = rd; bus_rr.mem_data = d;
        bus_fp.mem_valid = v; bus_fp.mem_rd = rd; bus_fp.mem_data = d;
    endtask

    task automatic set_issue(input logic v, input logic [7:0] rd);
        bus_rr.issue_valid = v; bus_rr.issue_rd = rd;
        bus_fp.issue_valid = v; bus_fp.issue_rd = rd;
    endtask

    task automatic set_query(input logic [7:0] q1, input logic [7:0] q2);
        bus_rr.q_r1 = q1; bus_rr.q_r2 = q2;
        bus_fp.q_r1 = q1; bus_fp.q_r2 = q2;
    endtask

    task automatic idle();
        set_alu(1'b0, 8'd0, 32'd0);
        set_mem(1'b0, 8'd0, 32'd0);
        set_issue(1'b0, 8'd0);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        idle();
        set_query(8'd0, 8'd0);

        // ---- Reset state, with a request present during reset --------------
        set_alu(1'b1, 8'd5, 32'h1111_1111);
        set_mem(1'b1, 8'd6, 32'h2222_2222);
        @(negedge clock);
        #1;
        check("rst_alu_ready", {31'd0, bus_rr.alu_ready}, 32'd0);
        check("rst_mem_ready", {31'd0, bus_rr.mem_ready}, 32'd0);
        check("rst_wr_enable", {31'd0, bus_rr.wr_enable}, 32'd0);
        check("rst_wr_rw",     {24'd0, bus_rr.wr_rw},     32'd0);
        check("rst_wr_data",   bus_rr.wr_data,            32'd0);
        check("rst_pending",   bus_rr.pending,            32'd0);
        check("rst_wb_count",  bus_rr.wb_count,           32'd0);
        @(negedge clock);
        idle();
        reset_n = 1'b1;
        @(negedge clock);

        // ---- Lone ALU writeback: rd=5, 0xDEADBEEF --------------------------
        set_alu(1'b1, 8'd5, 32'hDEAD_BEEF);
        #1;
        check("lone_alu_ready", {31'd0, bus_rr.alu_ready}, 32'd1);
        check("lone_mem_ready", {31'd0, bus_rr.mem_ready}, 32'd0);
        next_cycle();
        idle();
        check("lone_wr_enable", {31'd0, bus_rr.wr_enable}, 32'd1);
        check("lone_wr_rw",     {24'd0, bus_rr.wr_rw},     32'd5);
        check("lone_wr_data",   bus_rr.wr_data,            32'hDEAD_BEEF);
        check("lone_wb_count",  bus_rr.wb_count,           32'd1);
        next_cycle();
        check("lone_wr_enable_drop", {31'd0, bus_rr.wr_enable}, 32'd0);

        // ---- Conflict: ALU rd=3 vs MEM rd=4 for three cycles ---------------
        // Last grant was ALU, so round-robin starts with MEM.
        set_alu(1'b1, 8'd3, 32'hA1A1_0003);
        set_mem(1'b1, 8'd4, 32'hB2B2_0004);
        #1;
        check("cf1_rr_mem_ready", {31'd0, bus_rr.mem_ready}, 32'd1);
        check("cf1_rr_alu_ready", {31'd0, bus_rr.alu_ready}, 32'd0);
        check("cf1_fp_mem_ready", {31'd0, bus_fp.mem_ready}, 32'd1);
        next_cycle();
        check("cf2_rr_wr_rw",     {24'd0, bus_rr.wr_rw},     32'd4);
        check("cf2_rr_wr_data",   bus_rr.wr_data,            32'hB2B2_0004);
        check("cf2_rr_alu_ready", {31'd0, bus_rr.alu_ready}, 32'd1);
        check("cf2_rr_mem_ready", {31'd0, bus_rr.mem_ready}, 32'd0);
        check("cf2_fp_mem_ready", {31'd0, bus_fp.mem_ready}, 32'd1);
        check("cf2_fp_alu_ready", {31'd0, bus_fp.alu_ready}, 32'd0);
        next_cycle();
        check("cf3_rr_wr_rw",     {24'd0, bus_rr.wr_rw},     32'd3);
        check("cf3_rr_wr_data",   bus_rr.wr_data,            32'hA1A1_0003);
        check("cf3_rr_mem_ready", {31'd0, bus_rr.mem_ready}, 32'd1);
        check("cf3_rr_alu_ready", {31'd0, bus_rr.alu_ready}, 32'd0);
        check("cf3_fp_wr_rw",     {24'd0, bus_fp.wr_rw},     32'd4);
        check("cf3_fp_mem_ready", {31'd0, bus_fp.mem_ready}, 32'd1);
        next_cycle();
        idle();
        check("cf4_rr_wr_rw",    {24'd0, bus_rr.wr_rw}, 32'd4);
        check("cf4_rr_wb_count", bus_rr.wb_count,       32'd4);
        check("cf4_fp_wb_count", bus_fp.wb_count,       32'd4);
        next_cycle();

        // ---- Scoreboard: issue rd=7 (upper bits set), query, MEM commit ----
        set_issue(1'b1, 8'hE7);
        next_cycle();
        set_issue(1'b0, 8'd0);
        set_query(8'h27, 8'd0);
        #1;
        check("sb_pending_set", bus_rr.pending,        32'h0000_0080);
        check("sb_stall_q1",    {31'd0, bus_rr.stall}, 32'd1);
        set_mem(1'b1, 8'd7, 32'h1234_5678);
        #1;
        check("sb_mem_ready", {31'd0, bus_rr.mem_ready}, 32'd1);
        check("sb_stall_hold", {31'd0, bus_rr.stall},    32'd1);
        next_cycle();
        idle();
        check("sb_stall_clear", {31'd0, bus_rr.stall},     32'd0);
        check("sb_pending_clr", bus_rr.pending,            32'd0);
        check("sb_wr_enable",   {31'd0, bus_rr.wr_enable}, 32'd1);
        check("sb_wr_rw",       {24'd0, bus_rr.wr_rw},     32'd7);
        check("sb_wr_data",     bus_rr.wr_data,            32'h1234_5678);
        set_query(8'd0, 8'd0);
        next_cycle();

        // ---- Set/clear collision on rd=9 ------------------------------------
        set_issue(1'b1, 8'd9);
        next_cycle();
        set_alu(1'b1, 8'd9, 32'h9999_0009);
        next_cycle();
        idle();
        set_query(8'd0, 8'd9);
        #1;
        check("col_pending",   bus_rr.pending,            32'h0000_0200);
        check("col_stall_q2",  {31'd0, bus_rr.stall},     32'd1);
        check("col_wr_enable", {31'd0, bus_rr.wr_enable}, 32'd1);
        check("col_wr_rw",     {24'd0, bus_rr.wr_rw},     32'd9);
        set_mem(1'b1, 8'd9, 32'h0000_0909);
        next_cycle();
        idle();
        check("col_pending_clr", bus_rr.pending,        32'd0);
        check("col_stall_clr",   {31'd0, bus_rr.stall}, 32'd0);
        set_query(8'd0, 8'd0);
        next_cycle();

        // ---- rd=0: consumed, no write, no count, never pending -------------
        // Count so far: 1 lone + 3 conflict + 1 scoreboard + 2 collision = 7.
        set_alu(1'b1, 8'h20, 32'hFFFF_FFFF);
        set_issue(1'b1, 8'h40);
        #1;
        check("r0_alu_ready", {31'd0, bus_rr.alu_ready}, 32'd1);
        next_cycle();
        idle();
        check("r0_wr_enable", {31'd0, bus_rr.wr_enable}, 32'd0);
        check("r0_wb_count",  bus_rr.wb_count,           32'd7);
        check("r0_pending",   bus_rr.pending,            32'd0);
        next_cycle();

        // ---- Reset mid-operation --------------------------------------------
        set_issue(1'b1, 8'd7);
        next_cycle();
        set_issue(1'b0, 8'd0);
        check("mid_pending_pre", bus_rr.pending, 32'h0000_0080);
        set_alu(1'b1, 8'd2, 32'hCAFE_0002);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_pending",   bus_rr.pending,            32'd0);
        check("mid_wr_enable", {31'd0, bus_rr.wr_enable}, 32'd0);
        check("mid_wb_count",  bus_rr.wb_count,           32'd0);
        check("mid_alu_ready", {31'd0, bus_rr.alu_ready}, 32'd0);
        check("mid_wr_data",   bus_rr.wr_data,            32'd0);
        @(negedge clock);
        check("mid_no_pulse", {31'd0, bus_rr.wr_enable}, 32'd0);
        reset_n = 1'b1;
        set_alu(1'b1, 8'd3, 32'hA1A1_0003);
        set_mem(1'b1, 8'd4, 32'hB2B2_0004);
        #1;
        check("post_rr_mem_ready", {31'd0, bus_rr.mem_ready}, 32'd1);
        check("post_rr_alu_ready", {31'd0, bus_rr.alu_ready}, 32'd0);
        check("post_fp_mem_ready", {31'd0, bus_fp.mem_ready}, 32'd1);
        next_cycle();
        idle();
        check("post_wr_enable", {31'd0, bus_rr.wr_enable}, 32'd1);
        check("post_wr_rw",     {24'd0, bus_rr.wr_rw},     32'd4);
        check("post_wb_count",  bus_rr.wb_count,           32'd1);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
